axis_sa_out_transpose: RTL and testbench

//  Downstream of axis_sa. Accepts output tiles as column vectors (R values per beat, last column first,
//  C beats per tile) and re-emits each tile row-major: one beat per row, C values, column 0 at index 0.
//  Two-bank ping-pong buffer: one tile fills while the previous drains, so back-to-back tiles stream

---
 rtl/axis_sa_out_transpose.sv | 109 ++++++++++
 tb/tb_axis_sa_out_transpose.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sa_out_transpose.sv
// Column-to-row tile transposer behind the systolic array: ping-pong banks let
// one tile fill column-by-column while the other drains row-by-row.
module axis_sa_out_transpose #(
  parameter int unsigned R  = 2,
  parameter int unsigned C  = 2,
  parameter int unsigned WY = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  input  logic [R-1:0][WY-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic [C-1:0][WY-1:0] m_data,
  output logic                 err_last
);

  localparam int unsigned WCW = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned RCW = (R > 1) ? $clog2(R) : 1;

  logic [WY-1:0]  bank_q [2][R][C];
  logic [WY-1:0]  bank_d [2][R][C];
  logic [1:0]     full_q, full_d;
  logic           wb_q, wb_d, rb_q, rb_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic           err_q, err_d;
  logic           acc, pop, wlast, rlast;

  always_comb begin
    s_ready  = ~full_q[wb_q];
    m_valid  = full_q[rb_q];
    wlast    = (wcnt_q == WCW'(C - 1));
    rlast    = (rcnt_q == RCW'(R - 1));
    acc      = s_valid & s_ready;
    pop      = m_valid & m_ready;
    m_last   = m_valid & rlast;
    err_last = err_q;

    m_data = '0;
    for (int unsigned r = 0; r < R; r++) begin
      for (int unsigned c = 0; c < C; c++) begin
        if (rcnt_q == RCW'(r)) m_data[c] = bank_q[rb_q][r][c];
      end
    end

    bank_d = bank_q;
    full_d = full_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    err_d  = err_q;

    // Columns arrive last-first: beat k lands in column C-1-k.
    if (acc) begin
      for (int unsigned r = 0; r < R; r++) begin
        for (int unsigned c = 0; c < C; c++) begin
          if (wcnt_q == WCW'(C - 1 - c)) bank_d[wb_q][r][c] = s_data[r];
        end
      end
      if (s_last != wlast) err_d = 1'b1;
      if (wlast) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        wcnt_d       = '0;
      end else begin
        wcnt_d = wcnt_q + WCW'(1);
      end
    end

    // acc needs bank wb empty and pop needs bank rb full, so they never hit the same bank.
    if (pop) begin
      if (rlast) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
        rcnt_d       = '0;
      end else begin
        rcnt_d = rcnt_q + RCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      wcnt_q <= '0;
      rcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

endmodule

// File: tb/tb_axis_sa_out_transpose.sv
// Bench for axis_sa_out_transpose: a 2x2 instance for directed cases and a
// 3x2 instance for randomized traffic, both checked against a row scoreboard.
module tb_axis_sa_out_transpose;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- DUT A: R=2, C=2 ----------------
  logic             a_s_valid = 1'b0, a_s_ready, a_s_last = 1'b0;
  logic [1:0][9:0]  a_s_data = '0;
  logic             a_m_valid, a_m_ready = 1'b1, a_m_last, a_err;
  logic [1:0][9:0]  a_m_data;

  axis_sa_out_transpose #(.R(2), .C(2), .WY(10)) u_a (
    .clk(clk), .rst(rst), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_last(a_s_last),
    .s_data(a_s_data), .m_valid(a_m_valid), .m_ready(a_m_ready), .m_last(a_m_last),
    .m_data(a_m_data), .err_last(a_err));

  // ---------------- DUT B: R=3, C=2 ----------------
  logic             b_s_valid = 1'b0, b_s_ready, b_s_last = 1'b0;
  logic [2:0][9:0]  b_s_data = '0;
  logic             b_m_valid, b_m_ready = 1'b0, b_m_last, b_err;
  logic [1:0][9:0]  b_m_data;

  axis_sa_out_transpose #(.R(3), .C(2), .WY(10)) u_b (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_last(b_s_last),
    .s_data(b_s_data), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_last(b_m_last),
    .m_data(b_m_data), .err_last(b_err));

  // Scoreboards: entries are {last, row}; row[c] = value from beat C-1-c, element r.
  logic [20:0]     qa[$];
  logic [20:0]     qb[$];
  logic [1:0][9:0] a_cols [2];
  logic [2:0][9:0] b_cols [2];
  int a_col = 0, b_col = 0;
  int a_acc = 0, a_pops = 0, a_stalls = 0, b_pops = 0;

  always @(negedge clk) begin
    logic [1:0][9:0] row;
    logic [20:0]     e;
    if (rst) begin
      qa.delete();
      a_col = 0;
    end else begin
      if (a_s_valid && a_s_ready) begin
        a_cols[a_col] = a_s_data;
        a_col++;
        a_acc++;
        if (a_col == 2) begin
          for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) row[c] = a_cols[1 - c][r];
            qa.push_back({(r == 1), row});
          end
          a_col = 0;
        end
      end
      if (a_m_valid && a_m_ready) begin
        a_pops++;
        if (qa.size() == 0) check_eq("a_unexpected_beat", 64'(a_m_data), 64'h0 - 1);
        else begin
          e = qa.pop_front();
          check_eq("a_row", 64'({a_m_last, a_m_data}), 64'(e));
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0][9:0] row;
    logic [20:0]     e;
    if (rst) begin
      qb.delete();
      b_col = 0;
    end else begin
      if (b_s_valid && b_s_ready) begin
        b_cols[b_col] = b_s_data;
        b_col++;
        if (b_col == 2) begin
          for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) row[c] = b_cols[1 - c][r];
            qb.push_back({(r == 2), row});
          end
          b_col = 0;
        end
      end
      if (b_m_valid && b_m_ready) begin
        b_pops++;
        if (qb.size() == 0) check_eq("b_unexpected_beat", 64'(b_m_data), 64'h0 - 1);
        else begin
          e = qb.pop_front();
          check_eq("b_row", 64'({b_m_last, b_m_data}), 64'(e));
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic a_beat(input logic [9:0] d0, input logic [9:0] d1, input logic last);
    int n = 0;
    a_s_valid = 1'b1;
    a_s_data  = {d1, d0};
    a_s_last  = last;
    @(negedge clk);
    while (!a_s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n > 0) a_stalls++;
    if (n >= 200) check_eq("a_beat_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    a_s_valid = 1'b0;
    a_s_last  = 1'b0;
  endtask

  task automatic a_tile(input int base);
    a_beat(10'(base + 1), 10'(base + 2), 1'b0);
    a_beat(10'(base + 3), 10'(base + 4), 1'b1);
  endtask

  task automatic drain_a();
    int n = 0;
    while ((qa.size() != 0 || a_m_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("a_drain_timeout", 64'(n < 200), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int acc0;
    int beat;
    int cyc;
    bit done;
    logic [1:0][9:0] exp_row;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_s_ready", 64'(a_s_ready), 64'd1);
    check_eq("rst_m_valid", 64'(a_m_valid), 64'd0);
    check_eq("rst_m_last", 64'(a_m_last), 64'd0);
    check_eq("rst_err_last", 64'(a_err), 64'd0);
    @(posedge clk);
    #1;

    // 1) single tile, latency and exact values
    a_m_ready = 1'b1;
    a_beat(10'd6, 10'd12, 1'b0);
    a_beat(10'h3f1, 10'd25, 1'b1);
    @(negedge clk);
    exp_row = {10'd6, 10'h3f1};
    check_eq("t1_latency_valid", 64'(a_m_valid), 64'd1);
    check_eq("t1_row0", 64'(a_m_data), 64'(exp_row));
    check_eq("t1_row0_last", 64'(a_m_last), 64'd0);
    @(negedge clk);
    exp_row = {10'd12, 10'd25};
    check_eq("t1_row1", 64'(a_m_data), 64'(exp_row));
    check_eq("t1_row1_last", 64'(a_m_last), 64'd1);
    check_eq("t1_err_last", 64'(a_err), 64'd0);
    drain_a();

    // 2) four tiles back-to-back with m_ready high
    a_pops = 0;
    a_stalls = 0;
    for (int t = 0; t < 4; t++) a_tile(20 + 10 * t);
    drain_a();
    check_eq("t2_no_stall", 64'(a_stalls), 64'd0);
    check_eq("t2_out_beats", 64'(a_pops), 64'd8);

    // 3) downstream blocked while feeding three tiles
    a_m_ready = 1'b0;
    a_pops = 0;
    acc0 = a_acc;
    fork
      begin
        for (int t = 0; t < 3; t++) a_tile(100 + 10 * t);
      end
      begin
        repeat (8) @(negedge clk);
        check_eq("t3_accepted", 64'(a_acc - acc0), 64'd4);
        check_eq("t3_s_ready_low", 64'(a_s_ready), 64'd0);
        exp_row = {10'd101, 10'd103};
        check_eq("t3_hold_a", 64'(a_m_data), 64'(exp_row));
        repeat (2) @(negedge clk);
        check_eq("t3_hold_b", 64'(a_m_data), 64'(exp_row));
        check_eq("t3_hold_valid", 64'(a_m_valid), 64'd1);
        @(posedge clk);
        #1;
        a_m_ready = 1'b1;
      end
    join
    drain_a();
    check_eq("t3_out_beats", 64'(a_pops), 64'd6);

    // 4) s_last on the first beat of a tile
    a_beat(10'd7, 10'd8, 1'b1);
    a_beat(10'd9, 10'd10, 1'b1);
    @(negedge clk);
    check_eq("t4_err_set", 64'(a_err), 64'd1);
    @(posedge clk);
    #1;
    a_tile(300);
    drain_a();
    check_eq("t4_err_sticky", 64'(a_err), 64'd1);

    // 5) reset mid-fill and mid-drain
    a_beat(10'd1, 10'd2, 1'b0);
    reset_pulse();
    @(negedge clk);
    check_eq("t5a_s_ready", 64'(a_s_ready), 64'd1);
    check_eq("t5a_m_valid", 64'(a_m_valid), 64'd0);
    check_eq("t5a_err_clr", 64'(a_err), 64'd0);
    @(posedge clk);
    #1;
    a_m_ready = 1'b0;
    a_tile(400);
    a_m_ready = 1'b1;
    @(posedge clk);
    #1;
    a_m_ready = 1'b0;
    reset_pulse();
    @(negedge clk);
    check_eq("t5b_s_ready", 64'(a_s_ready), 64'd1);
    check_eq("t5b_m_valid", 64'(a_m_valid), 64'd0);
    check_eq("t5b_m_last", 64'(a_m_last), 64'd0);
    @(posedge clk);
    #1;
    a_m_ready = 1'b1;
    a_pops = 0;
    a_tile(500);
    drain_a();
    check_eq("t5_fresh_beats", 64'(a_pops), 64'd2);

    // 6) random valid/ready on the 3x2 instance
    b_pops = 0;
    beat = 0;
    cyc = 0;
    done = 1'b0;
    b_s_data = {10'($urandom), 10'($urandom), 10'($urandom)};
    fork
      begin
        while (beat < 200 && cyc < 5000) begin
          b_s_valid = 1'($urandom_range(0, 1));
          b_s_last  = (beat % 2 == 1);
          @(negedge clk);
          if (b_s_valid && b_s_ready) begin
            beat++;
            @(posedge clk);
            #1;
            b_s_data = {10'($urandom), 10'($urandom), 10'($urandom)};
          end else begin
            @(posedge clk);
            #1;
          end
          cyc++;
        end
        b_s_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          b_m_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        b_m_ready = 1'b1;
      end
    join
    check_eq("t6_inputs_sent", 64'(beat), 64'd200);
    cyc = 0;
    while ((qb.size() != 0 || b_m_valid) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t6_drain_timeout", 64'(cyc < 500), 64'd1);
    check_eq("t6_out_beats", 64'(b_pops), 64'd300);
    check_eq("t6_err_last", 64'(b_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
